// File: rtl/uart_file_xfer.sv
// uart_file_xfer: moves a size-prefixed byte stream between a UART byte channel and a 32-bit
// word memory port. Optional rx inactivity abort is built when FILE_XFER_TIMEOUT_EN is defined.
module uart_file_xfer #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              start_finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       dump_size,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       xfer_size,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  localparam logic [7:0] CMD_LOAD   = 8'h02;
  localparam logic [7:0] CMD_DUMP   = 8'h03;
  localparam logic [7:0] CMD_FINISH = 8'h04;

  typedef enum logic [3:0] {
    IDLE, SEND_CMD, RX_SIZE, RX_DATA, MEM_WR, TX_SIZE, MEM_RD, TX_DATA, DONE
  } state_t;

  typedef enum logic [1:0] {OP_LOAD, OP_DUMP, OP_FINISH} op_t;

  state_t            state, state_nx;
  op_t               op, op_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [31:0]       cnt, cnt_nx, cnt_inc;
  logic [31:0]       rbuf, rbuf_nx;
  logic [31:0]       xfer_size_nx;
  logic              error_nx;
  logic [7:0]        tx_data_nx;
  logic              tx_valid_nx;
  logic              mem_valid_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [31:0]       mem_wdata_nx;
  logic [3:0]        mem_wstrb_nx;
  logic              rx_hs, tx_hs;
  logic [1:0]        lane;

  // Strobe mask covering lanes 0..last_lane of a word.
  function automatic logic [3:0] lane_strb(input logic [1:0] last_lane);
    case (last_lane)
      2'd0:    return 4'h1;
      2'd1:    return 4'h3;
      2'd2:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  // Address of the word holding byte byte_idx; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [31:0]       byte_idx);
    return b + ADDR_W'({byte_idx[31:2], 2'b00});
  endfunction

  assign rx_ready = (state == RX_SIZE) || (state == RX_DATA);
  assign rx_hs    = rx_valid && rx_ready;
  assign tx_hs    = tx_valid && tx_ready;
  assign lane     = cnt[1:0];
  assign cnt_inc  = cnt + 32'd1;

`ifdef FILE_XFER_TIMEOUT_EN
  logic [31:0] tmo, tmo_nx;
`else
  logic cfg_unused;
  assign cfg_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_nx     = state;
    op_nx        = op;
    base_nx      = base;
    cnt_nx       = cnt;
    rbuf_nx      = rbuf;
    xfer_size_nx = xfer_size;
    error_nx     = error;
    tx_data_nx   = tx_data;
    tx_valid_nx  = tx_valid;
    mem_valid_nx = mem_valid;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_wstrb_nx = mem_wstrb;

    case (state)
      IDLE: begin
        if (start_load || start_dump || start_finish) begin
          base_nx     = base_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
          error_nx    = 1'b0;
          cnt_nx      = '0;
          tx_valid_nx = 1'b1;
          state_nx    = SEND_CMD;
          if (start_load) begin
            op_nx        = OP_LOAD;
            tx_data_nx   = CMD_LOAD;
            xfer_size_nx = '0;
          end else if (start_dump) begin
            op_nx        = OP_DUMP;
            tx_data_nx   = CMD_DUMP;
            xfer_size_nx = dump_size;
          end else begin
            op_nx      = OP_FINISH;
            tx_data_nx = CMD_FINISH;
          end
        end
      end
      SEND_CMD: begin
        if (tx_hs) begin
          case (op)
            OP_LOAD: begin
              tx_valid_nx = 1'b0;
              state_nx    = RX_SIZE;
            end
            OP_DUMP: begin
              tx_data_nx = xfer_size[7:0];
              state_nx   = TX_SIZE;
            end
            default: begin
              tx_valid_nx = 1'b0;
              state_nx    = DONE;
            end
          endcase
        end
      end
      RX_SIZE: begin
        if (rx_hs) begin
          xfer_size_nx[{lane, 3'b000} +: 8] = rx_data;
          cnt_nx = cnt_inc;
          if (lane == 2'd3) begin
            cnt_nx   = '0;
            state_nx = ({rx_data, xfer_size[23:0]} == 32'd0) ? DONE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_hs) begin
          // A new word starts clean so unused lanes of a partial word read as zero.
          if (lane == 2'd0) mem_wdata_nx = {24'h0, rx_data};
          else              mem_wdata_nx[{lane, 3'b000} +: 8] = rx_data;
          cnt_nx = cnt_inc;
          if (lane == 2'd3 || cnt_inc == xfer_size) begin
            mem_valid_nx = 1'b1;
            mem_addr_nx  = word_addr(base, cnt);
            mem_wstrb_nx = lane_strb(lane);
            state_nx     = MEM_WR;
          end
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          mem_valid_nx = 1'b0;
          mem_wstrb_nx = 4'h0;
          state_nx     = (cnt == xfer_size) ? DONE : RX_DATA;
        end
      end
      TX_SIZE: begin
        if (tx_hs) begin
          if (lane == 2'd3) begin
            tx_valid_nx = 1'b0;
            cnt_nx      = '0;
            if (xfer_size == 32'd0) begin
              state_nx = DONE;
            end else begin
              mem_valid_nx = 1'b1;
              mem_addr_nx  = base;
              mem_wstrb_nx = 4'h0;
              state_nx     = MEM_RD;
            end
          end else begin
            cnt_nx     = cnt_inc;
            tx_data_nx = xfer_size[{cnt_inc[1:0], 3'b000} +: 8];
          end
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          mem_valid_nx = 1'b0;
          rbuf_nx      = mem_rdata;
          tx_data_nx   = mem_rdata[{lane, 3'b000} +: 8];
          tx_valid_nx  = 1'b1;
          state_nx     = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_hs) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == xfer_size) begin
            tx_valid_nx = 1'b0;
            state_nx    = DONE;
          end else if (lane == 2'd3) begin
            tx_valid_nx  = 1'b0;
            mem_valid_nx = 1'b1;
            mem_addr_nx  = word_addr(base, cnt_inc);
            mem_wstrb_nx = 4'h0;
            state_nx     = MEM_RD;
          end else begin
            tx_data_nx = rbuf[{cnt_inc[1:0], 3'b000} +: 8];
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

`ifdef FILE_XFER_TIMEOUT_EN
    // Idle rx cycles abort the transfer; words already written stay in memory.
    tmo_nx = '0;
    if (rx_ready && !rx_hs) begin
      if (tmo + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
        state_nx = DONE;
        error_nx = 1'b1;
      end else begin
        tmo_nx = tmo + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      xfer_size <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
      error     <= error_nx;
      xfer_size <= xfer_size_nx;
      tx_data   <= tx_data_nx;
      tx_valid  <= tx_valid_nx;
      mem_valid <= mem_valid_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_wstrb <= mem_wstrb_nx;
    end
  end

  always_ff @(posedge clk) begin
    op   <= op_nx;
    base <= base_nx;
    rbuf <= rbuf_nx;
  end

`ifdef FILE_XFER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo <= '0;
    else     tmo <= tmo_nx;
  end
`endif

endmodule

// File: tb/tb_uart_file_xfer.sv
// tb_uart_file_xfer: scoreboard bench for uart_file_xfer; behavioural host UART and memory,
// with expected tx bytes and memory writes queued before the DUT produces them.
`timescale 1ns/1ps
module tb_uart_file_xfer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_load, start_dump, start_finish;
  logic [31:0] base_addr, dump_size;
  logic        busy, done, error;
  logic [31:0] xfer_size;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  uart_file_xfer #(.ADDR_W(32), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .start_dump(start_dump), .start_finish(start_finish),
    .base_addr(base_addr), .dump_size(dump_size),
    .busy(busy), .done(done), .error(error), .xfer_size(xfer_size),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  logic [31:0] mem_m[logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        mon_en = 1'b0;
  int          tx_hold = 0, tx_count = 0, tx_hs_cyc = 0;
  logic        tx_pend = 1'b0;
  logic [7:0]  tx_prev, tx_exp;
  int          mem_delay = 0, mem_wait = 0, rd_count = 0;
  logic        mem_pend = 1'b0, drop_chk = 1'b0;
  logic [31:0] mp_addr, mp_wdata, wr_word;
  logic [3:0]  mp_strb;
  wr_t         ew;
  int          last_rx_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Host UART sink: takes tx bytes, applies optional hold-off, checks order and stability.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tx_pend) begin
          n_checks++;
          if (tx_valid !== 1'b1 || tx_data !== tx_prev) begin
            n_fail++;
            $display("FAIL tx_stable: valid=%b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, tx_prev);
          end
        end
        if (tx_hold > 0) begin
          tx_ready = 1'b0;
          tx_hold--;
        end else begin
          tx_ready = 1'b1;
        end
        if (tx_valid) begin
          n_checks++;
          if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_ready_while_tx: rx_ready=%b, required 0", rx_ready);
          end
        end
        tx_pend = 1'b0;
        if (tx_valid && tx_ready) begin
          n_checks++;
          tx_count++;
          tx_hs_cyc = cyc;
          if (exp_tx.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got %02h, required no byte", tx_data);
          end else begin
            tx_exp = exp_tx.pop_front();
            if (tx_data !== tx_exp) begin
              n_fail++;
              $display("FAIL tx_byte: got %02h, required %02h", tx_data, tx_exp);
            end
          end
        end else if (tx_valid) begin
          tx_pend = 1'b1;
          tx_prev = tx_data;
        end
      end
    end
  end

  // Memory model: optional ready delay, checks writes against the scoreboard, serves reads.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (drop_chk) begin
          n_checks++;
          if (mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_valid_drop: mem_valid=%b, required 0", mem_valid);
          end
          drop_chk = 1'b0;
        end else if (mem_pend) begin
          n_checks++;
          if (mem_valid !== 1'b1 || mem_addr !== mp_addr || mem_wdata !== mp_wdata || mem_wstrb !== mp_strb) begin
            n_fail++;
            $display("FAIL mem_stable: v=%b a=%08h d=%08h s=%h, required v=1 a=%08h d=%08h s=%h",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, mp_addr, mp_wdata, mp_strb);
          end
        end
        mem_pend  = 1'b0;
        mem_ready = 1'b0;
        if (mem_valid) begin
          if (mem_wait > 0) begin
            mem_wait--;
            mem_pend = 1'b1;
            mp_addr  = mem_addr;
            mp_wdata = mem_wdata;
            mp_strb  = mem_wstrb;
          end else begin
            mem_ready = 1'b1;
            drop_chk  = 1'b1;
            mem_wait  = mem_delay;
            if (mem_wstrb == 4'h0) begin
              rd_count++;
              mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
            end else begin
              n_checks++;
              if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL mem_unexpected_write: a=%08h d=%08h s=%h, required no write", mem_addr, mem_wdata, mem_wstrb);
              end else begin
                ew = exp_wr.pop_front();
                if (mem_addr !== ew.addr || mem_wdata !== ew.data || mem_wstrb !== ew.strb) begin
                  n_fail++;
                  $display("FAIL mem_write: a=%08h d=%08h s=%h, required a=%08h d=%08h s=%h",
                           mem_addr, mem_wdata, mem_wstrb, ew.addr, ew.data, ew.strb);
                end
              end
              wr_word = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
              for (int i = 0; i < 4; i++)
                if (mem_wstrb[i]) wr_word[i*8 +: 8] = mem_wdata[i*8 +: 8];
              mem_m[mem_addr] = wr_word;
            end
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic ld, input logic dp, input logic fn,
                             input logic [31:0] base, input logic [31:0] dsz);
    @(negedge clk);
    start_load = ld; start_dump = dp; start_finish = fn;
    base_addr = base; dump_size = dsz;
    @(negedge clk);
    start_load = 1'b0; start_dump = 1'b0; start_finish = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: busy=%b, required 1", busy);
    end
  endtask

  task automatic host_send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_accept_timeout: byte %02h not taken, required rx_ready", b);
    end else begin
      @(posedge clk);
      #1;
      last_rx_cyc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    logic ok;
    ok   = 1'b0;
    dcyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        ok   = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    n_checks++;
    if (!ok || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_seen: done_found=%b busy=%b, required done pulse with busy=1", ok, busy);
    end else begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: %b, required 0", done); end
    n_checks++; if (error !== 1'b0)     begin n_fail++; $display("FAIL rst_error: %b, required 0", error); end
    n_checks++; if (xfer_size !== 32'h0) begin n_fail++; $display("FAIL rst_xfer_size: %08h, required 0", xfer_size); end
    n_checks++; if (rx_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_rx_ready: %b, required 0", rx_ready); end
    n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_valid: %b, required 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h0)   begin n_fail++; $display("FAIL rst_tx_data: %02h, required 0", tx_data); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: %b, required 0", mem_valid); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: %08h, required 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: %08h, required 0", mem_wdata); end
    n_checks++; if (mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_mem_wstrb: %h, required 0", mem_wstrb); end
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load8;
    logic [7:0] pl[$];
    int dc;
    pl = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    mem_delay = 0; mem_wait = 0;
    exp_tx.push_back(8'h02);
    exp_wr.push_back(wr_t'{32'h100, 32'h44332211, 4'hF});
    exp_wr.push_back(wr_t'{32'h104, 32'h88776655, 4'hF});
    pulse_start(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    foreach (pl[i]) host_send(pl[i]);
    wait_done(dc);
    n_checks++; if (xfer_size !== 32'd8) begin n_fail++; $display("FAIL load8_size: %0d, required 8", xfer_size); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL load8_error: %b, required 0", error); end
    n_checks++;
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL load8_drain: %0d tx / %0d writes left, required 0/0", exp_tx.size(), exp_wr.size());
    end
  endtask

  task automatic test_partial_load;
    logic [7:0] pl[$];
    int dc;
    pl = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    exp_tx.push_back(8'h02);
    exp_wr.push_back(wr_t'{32'h100, 32'hDDCCBBAA, 4'hF});
    exp_wr.push_back(wr_t'{32'h104, 32'h000000EE, 4'h1});
    pulse_start(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    foreach (pl[i]) host_send(pl[i]);
    wait_done(dc);
    n_checks++; if (xfer_size !== 32'd5) begin n_fail++; $display("FAIL partial_size: %0d, required 5", xfer_size); end
    n_checks++;
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL partial_drain: %0d tx / %0d writes left, required 0/0", exp_tx.size(), exp_wr.size());
    end
  endtask

  task automatic test_dump;
    logic [7:0] ex[$];
    int dc;
    ex = '{8'h03, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    mem_m[32'h200] = 32'h04030201;
    mem_m[32'h204] = 32'h00000605;
    rd_count = 0;
    foreach (ex[i]) exp_tx.push_back(ex[i]);
    pulse_start(1'b0, 1'b1, 1'b0, 32'h200, 32'd6);
    wait_done(dc);
    n_checks++; if (rd_count != 2) begin n_fail++; $display("FAIL dump_reads: %0d, required 2", rd_count); end
    n_checks++; if (xfer_size !== 32'd6) begin n_fail++; $display("FAIL dump_size: %0d, required 6", xfer_size); end
    n_checks++; if (exp_tx.size() != 0) begin n_fail++; $display("FAIL dump_drain: %0d bytes left, required 0", exp_tx.size()); end
  endtask

  task automatic test_priority_finish;
    int dc;
    rd_count = 0;
    exp_tx.push_back(8'h03);
    repeat (4) exp_tx.push_back(8'h00);
    pulse_start(1'b0, 1'b1, 1'b1, 32'h0, 32'd0);
    wait_done(dc);
    n_checks++; if (rd_count != 0) begin n_fail++; $display("FAIL prio_reads: %0d, required 0", rd_count); end
    n_checks++; if (exp_tx.size() != 0) begin n_fail++; $display("FAIL prio_drain: %0d bytes left, required 0", exp_tx.size()); end
    exp_tx.push_back(8'h04);
    pulse_start(1'b0, 1'b0, 1'b1, 32'h0, 32'd0);
    wait_done(dc);
    n_checks++; if (dc != tx_hs_cyc + 1) begin n_fail++; $display("FAIL finish_done_latency: %0d, required %0d", dc - tx_hs_cyc, 1); end
    n_checks++; if (exp_tx.size() != 0) begin n_fail++; $display("FAIL finish_drain: %0d bytes left, required 0", exp_tx.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ex[$];
    logic [7:0] pl[$];
    logic ok;
    int dc, t0;
    ex = '{8'h03, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    mem_m[32'h400] = 32'h13121110;
    mem_m[32'h404] = 32'h17161514;
    mem_delay = 5; mem_wait = 5;
    rd_count = 0;
    foreach (ex[i]) exp_tx.push_back(ex[i]);
    t0 = tx_count;
    pulse_start(1'b0, 1'b1, 1'b0, 32'h403, 32'd8);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tx_count >= t0 + 7) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_progress: %0d bytes, required 7", tx_count - t0); end
    tx_hold = 10;
    wait_done(dc);
    n_checks++; if (rd_count != 2) begin n_fail++; $display("FAIL bp_reads: %0d, required 2", rd_count); end
    n_checks++; if (exp_tx.size() != 0) begin n_fail++; $display("FAIL bp_dump_drain: %0d bytes left, required 0", exp_tx.size()); end
    pl = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_tx.push_back(8'h02);
    exp_wr.push_back(wr_t'{32'h500, 32'hA4A3A2A1, 4'hF});
    tx_hold = 10;
    pulse_start(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    foreach (pl[i]) host_send(pl[i]);
    wait_done(dc);
    n_checks++;
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL bp_load_drain: %0d tx / %0d writes left, required 0/0", exp_tx.size(), exp_wr.size());
    end
    mem_delay = 0; mem_wait = 0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] pl[$];
    pl = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    exp_tx.push_back(8'h02);
    pulse_start(1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
    foreach (pl[i]) host_send(pl[i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, error, xfer_size, rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_outputs: busy=%b size=%08h rx_ready=%b tx_valid=%b mem_valid=%b wdata=%08h, required all 0",
               busy, xfer_size, rx_ready, tx_valid, mem_valid, mem_wdata);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_quiet: mem_valid=%b busy=%b, required 0 0", mem_valid, busy);
    end
  endtask

`ifdef FILE_XFER_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] pl[$];
    int dc;
    pl = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    exp_tx.push_back(8'h02);
    pulse_start(1'b1, 1'b0, 1'b0, 32'h700, 32'h0);
    foreach (pl[i]) host_send(pl[i]);
    wait_done(dc);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: %b, required 1", error); end
    n_checks++; if (dc != last_rx_cyc + 50) begin n_fail++; $display("FAIL timeout_latency: %0d, required 50", dc - last_rx_cyc); end
    exp_tx.push_back(8'h04);
    pulse_start(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: %b, required 0", error); end
    wait_done(dc);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_load = 1'b0; start_dump = 1'b0; start_finish = 1'b0;
    base_addr = '0; dump_size = '0;
    rx_data = '0; rx_valid = 1'b0;
    test_reset;
    test_load8;
    test_partial_load;
    test_dump;
    test_priority_finish;
    test_back_to_back;
    test_reset_mid;
`ifdef FILE_XFER_TIMEOUT_EN
    test_timeout;
`endif
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_file_xfer.md
# uart_file_xfer

Device-side hardware engine for the UART file-transfer protocol used by the simulation and board hosts. Control bytes: 0x02 = request file from host, 0x03 = send file to host, 0x04 = finish. The block issues the control byte, exchanges the 4-byte little-endian size, and streams payload between the UART byte channel and a 32-bit word memory port. It sits between the system UART byte interface and main memory/DDR, and lets firmware load or dump images without per-byte CPU polling.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of memory port
- TIMEOUT_CYCLES, 1000000, rx inactivity limit (only with FILE_XFER_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start_load  in  1  pulse: request file (0x02), write to memory
- start_dump  in  1  pulse: send file (0x03), read from memory
- start_finish  in  1  pulse: send 0x04
- base_addr  in  ADDR_W  byte base address; bits [1:0] treated as 0
- dump_size  in  32  byte count for dump, sampled at start_dump
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky: timeout abort; cleared by next accepted start
- xfer_size  out  32  size received (load) or sent (dump)
- rx_data  in  8  received byte
- rx_valid  in  1  rx byte available
- rx_ready  out  1  byte consumed when rx_valid && rx_ready
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx request
- tx_ready  in  1  byte taken when tx_valid && tx_ready
- mem_valid  out  1  memory request
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_rdata  in  32  read data, valid when mem_ready
- mem_ready  in  1  request completes

## Operation
- States: IDLE, SEND_CMD, RX_SIZE, RX_DATA, MEM_WR, TX_SIZE, MEM_RD, TX_DATA, DONE.
- IDLE: start priority is load > dump > finish. Starts are ignored when not IDLE. An accepted start latches base_addr (and dump_size), clears error and byte counter, then goes to SEND_CMD with tx_data = 0x02/0x03/0x04.
- SEND_CMD: hold tx_valid until handshake. Then load goes to RX_SIZE, dump goes to TX_SIZE, finish goes to DONE.
- RX_SIZE: consume 4 bytes, LSB first, into xfer_size. Size 0 goes to DONE; otherwise go to RX_DATA.
- RX_DATA: byte k goes to lane k%4 of word k/4. After lane 3, or after the final byte, go to MEM_WR. rx_ready is low outside RX_SIZE/RX_DATA.
- MEM_WR: mem_addr = base + 4*(k/4). mem_wstrb = 4'hF, or only the valid low lanes for a partial final word (size%4 = 1 gives 4'h1, 2 gives 4'h3, 3 gives 4'h7). On mem_ready, return to RX_DATA or go to DONE.
- TX_SIZE: send dump_size as 4 bytes, LSB first. Size 0 goes to DONE.
- MEM_RD: mem_wstrb = 0. Capture mem_rdata on mem_ready, then go to TX_DATA.
- TX_DATA: send lanes 0..3 in order, stopping at the size. Return to MEM_RD for the next word or go to DONE.
- DONE: pulse done for one cycle, then IDLE.
- Byte counter and address are 32 bits. The address wraps modulo 2^ADDR_W; no error is raised.

## Timing
- Reset values: busy=0, done=0, error=0, xfer_size=0, rx_ready=0, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- rst mid-transfer returns to IDLE on the next edge. No partial memory write is issued after reset.
- busy goes high the cycle after an accepted start and stays high through DONE.
- tx_data, tx_valid, mem_* are registered and held stable until their handshake completes.
- mem_valid drops the cycle after mem_ready. A same-cycle ready on first assertion is allowed.
- Throughput: at most 1 rx byte per cycle. One MEM_WR/MEM_RD dwell of at least 1 cycle per word.

## Configuration
- FILE_XFER_TIMEOUT_EN defined: a counter runs in RX_SIZE/RX_DATA, reset on each rx handshake. When it reaches TIMEOUT_CYCLES, the block sets error, pulses done, and returns to IDLE. Bytes already written remain in memory.
- Undefined: no counter; the block waits indefinitely for rx bytes. error is constant 0.

## Test plan
- Load 8 bytes: start_load, base 0x100. Expect tx 0x02. Host sends 08 00 00 00 11 22 33 44 55 66 77 88. Expect writes 0x100←0x44332211 and 0x104←0x88776655, both wstrb F. done pulses, xfer_size = 8.
- Partial load: size 5, payload AA BB CC DD EE. Expect second write 0x104←0x000000EE with wstrb 4'h1.
- Dump 6 bytes: mem[0x200] = 0x04030201, mem[0x204] = 0x0000_0605. Expect tx 03 06 00 00 00 01 02 03 04 05 06. Exactly 2 reads occur.
- Finish and priority: start_finish and start_dump pulse in the same cycle. Expect only 0x03 transmitted. A later start_finish alone sends 0x04; done follows 1 cycle after the tx handshake.
- Back-pressure: tx_ready low for 10 cycles, mem_ready delayed 5 cycles. tx_data and mem_* stay stable throughout; the byte sequence is unchanged.
- Reset/timeout: rst asserted during RX_DATA returns all outputs to reset values. With FILE_XFER_TIMEOUT_EN and TIMEOUT_CYCLES = 50, stalling after 2 payload bytes gives error=1 and a done pulse at 50 idle cycles.
